// File: rtl/imem_loader.sv
// Streams a program image into instruction memory over valid/ready, appends a halt word,
// and holds the CPU in reset until the whole image has been written.
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] HALT_WORD  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [31:0]           checksum
);

    localparam logic [ADDR_WIDTH:0] DEPTH    = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] LAST_IDX = DEPTH - (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {IDLE, LOAD, TERM, RUN, ERR} state_t;

    state_t                state_q, state_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [31:0]           checksum_q, checksum_d;
    logic [31:0]           last_word_q, last_word_d;
    logic                  accept;

    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = 1'b1;
        done_d       = 1'b0;
        error_d      = error_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        last_word_d  = last_word_q;

        case (state_q)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_d      = LOAD;
                    word_count_d = '0;
                    checksum_d   = '0;
                    error_d      = 1'b0;
                end else if (state_q == RUN) begin
                    // Release only once the final write has already been issued.
                    cpu_hold_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
                    imem_wdata_d = in_data;
                    word_count_d = word_count_q + (ADDR_WIDTH+1)'(1);
                    checksum_d   = checksum_q + in_data;
                    last_word_d  = in_data;
                    if (in_last) begin
                        state_d = TERM;
                    end else if (word_count_q == LAST_IDX) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            TERM: begin
                if (word_count_q != DEPTH) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
                    imem_wdata_d = HALT_WORD;
                    state_d      = RUN;
                end else if (last_word_q == HALT_WORD) begin
                    // Memory is full but the image already ends in a halt word.
                    state_d = RUN;
                end else begin
                    state_d = ERR;
                    error_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
            checksum_q   <= '0;
            last_word_q  <= '0;
        end else begin
            state_q      <= state_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            last_word_q  <= last_word_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a full-size loader (8-bit address) and a 4-word loader
// share the word stream; each has its own start pulse and instruction-memory model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [31:0] in_data = '0;

    logic        a_in_ready, a_we, a_cpu_hold, a_done, a_error;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata, a_checksum;
    logic [8:0]  a_count;

    logic        b_in_ready, b_we, b_cpu_hold, b_done, b_error;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata, b_checksum;
    logic [2:0]  b_count;

    logic [31:0] a_mem [256];
    logic [31:0] b_mem [4];
    int          a_writes = 0, b_writes = 0;
    int          errors = 0, checks = 0;
    bit          sel = 1'b0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(8), .HALT_WORD(32'h0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(a_in_ready), .imem_we(a_we), .imem_addr(a_addr),
        .imem_wdata(a_wdata), .cpu_hold(a_cpu_hold), .done(a_done), .error(a_error),
        .word_count(a_count), .checksum(a_checksum)
    );

    imem_loader #(.ADDR_WIDTH(2), .HALT_WORD(32'h0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(b_in_ready), .imem_we(b_we), .imem_addr(b_addr),
        .imem_wdata(b_wdata), .cpu_hold(b_cpu_hold), .done(b_done), .error(b_error),
        .word_count(b_count), .checksum(b_checksum)
    );

    always @(posedge clk) begin
        if (a_we) begin a_mem[a_addr] <= a_wdata; a_writes <= a_writes + 1; end
        if (b_we) begin b_mem[b_addr] <= b_wdata; b_writes <= b_writes + 1; end
    end

    task automatic clear_models();
        for (int i = 0; i < 256; i++) a_mem[i] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) b_mem[i] = 32'hDEADBEEF;
        a_writes = 0;
        b_writes = 0;
    endtask

    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Offer one word after 'gap' idle cycles; returns on the negedge after it was accepted.
    task automatic push(input logic [31:0] d, input logic l, input int gap);
        int n;
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!(sel ? b_in_ready : a_in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL push_timeout: word %h not accepted in %0d cycles (required <20)", d, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({a_in_ready, a_we, a_addr, a_wdata, a_cpu_hold, a_done, a_error, a_count, a_checksum}
            !== {1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0, 9'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_a: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b cnt=%0d sum=%h required 0 0 0 0 1 0 0 0 0",
                     a_in_ready, a_we, a_addr, a_wdata, a_cpu_hold, a_done, a_error, a_count, a_checksum);
        end
        checks++;
        if ({b_in_ready, b_we, b_cpu_hold, b_done, b_error, b_count} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'h0}) begin
            errors++;
            $display("FAIL reset_b: rdy=%b we=%b hold=%b done=%b err=%b cnt=%0d required 0 0 1 0 0 0",
                     b_in_ready, b_we, b_cpu_hold, b_done, b_error, b_count);
        end
        reset = 1'b1;
    endtask

    task automatic check_t1_image(input string name, input int exp_writes);
        logic [31:0] prog [6];
        prog = '{32'h00A00313, 32'h00000393, 32'h40000413, 32'h0063A023, 32'h00642023, 32'h0};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (a_mem[i] !== prog[i]) begin
                errors++;
                $display("FAIL %s_mem%0d: got %h required %h", name, i, a_mem[i], prog[i]);
            end
        end
        checks++;
        if (a_count !== 9'd5 || a_checksum !== 32'h4167CAFF || a_writes != exp_writes) begin
            errors++;
            $display("FAIL %s_totals: cnt=%0d sum=%h writes=%0d required 5 4167caff %0d",
                     name, a_count, a_checksum, a_writes, exp_writes);
        end
        checks++;
        if (a_done !== 1'b1 || a_cpu_hold !== 1'b0 || a_error !== 1'b0) begin
            errors++;
            $display("FAIL %s_status: done=%b hold=%b err=%b required 1 0 0", name, a_done, a_cpu_hold, a_error);
        end
    endtask

    task automatic test_stream();
        sel = 1'b0;
        clear_models();
        pulse_start(1'b0);
        push(32'h00A00313, 1'b0, 0);
        push(32'h00000393, 1'b0, 0);
        push(32'h40000413, 1'b0, 0);
        push(32'h0063A023, 1'b0, 0);
        push(32'h00642023, 1'b1, 0);
        checks++;
        if (a_we !== 1'b1 || a_addr !== 8'd4 || a_wdata !== 32'h00642023 || a_cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL t1_last_write: we=%b addr=%0d wd=%h hold=%b required 1 4 00642023 1", a_we, a_addr, a_wdata, a_cpu_hold);
        end
        @(negedge clk);
        checks++;
        if (a_we !== 1'b1 || a_addr !== 8'd5 || a_wdata !== 32'h0 || a_cpu_hold !== 1'b1 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL t1_halt_write: we=%b addr=%0d wd=%h hold=%b done=%b required 1 5 0 1 0", a_we, a_addr, a_wdata, a_cpu_hold, a_done);
        end
        @(negedge clk);
        checks++;
        if (a_we !== 1'b0 || a_cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL t1_release: we=%b hold=%b required 0 0", a_we, a_cpu_hold);
        end
        check_t1_image("t1", 6);
    endtask

    task automatic test_gaps();
        sel = 1'b0;
        clear_models();
        pulse_start(1'b0);
        push(32'h00A00313, 1'b0, 2);
        push(32'h00000393, 1'b0, 0);
        push(32'h40000413, 1'b0, 3);
        push(32'h0063A023, 1'b0, 1);
        push(32'h00642023, 1'b1, 2);
        repeat (2) @(negedge clk);
        check_t1_image("t2", 6);
    endtask

    task automatic test_reload_from_run();
        sel = 1'b0;
        clear_models();
        pulse_start(1'b0);
        checks++;
        if (a_cpu_hold !== 1'b1 || a_done !== 1'b0 || a_count !== 9'd0 || a_checksum !== 32'h0) begin
            errors++;
            $display("FAIL t6_restart: hold=%b done=%b cnt=%0d sum=%h required 1 0 0 0", a_cpu_hold, a_done, a_count, a_checksum);
        end
        push(32'h11111111, 1'b0, 0);
        push(32'h22222222, 1'b1, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (a_count !== 9'd2 || a_checksum !== 32'h33333333 || a_done !== 1'b1 || a_cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL t6_status: cnt=%0d sum=%h done=%b hold=%b required 2 33333333 1 0", a_count, a_checksum, a_done, a_cpu_hold);
        end
        checks++;
        if (a_mem[0] !== 32'h11111111 || a_mem[1] !== 32'h22222222 || a_mem[2] !== 32'h0 || a_writes != 3) begin
            errors++;
            $display("FAIL t6_mem: m0=%h m1=%h m2=%h writes=%0d required 11111111 22222222 0 3", a_mem[0], a_mem[1], a_mem[2], a_writes);
        end
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        clear_models();
        pulse_start(1'b1);
        push(32'hA, 1'b0, 0);
        push(32'hB, 1'b0, 0);
        push(32'hC, 1'b0, 0);
        push(32'hD, 1'b0, 0);
        checks++;
        if (b_error !== 1'b1 || b_in_ready !== 1'b0 || b_cpu_hold !== 1'b1 || b_we !== 1'b1 || b_addr !== 2'd3) begin
            errors++;
            $display("FAIL t3_err: err=%b rdy=%b hold=%b we=%b addr=%0d required 1 0 1 1 3", b_error, b_in_ready, b_cpu_hold, b_we, b_addr);
        end
        in_valid = 1'b1;
        in_data  = 32'hE;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (b_writes != 4 || b_count !== 3'd4 || b_mem[3] !== 32'hD || b_error !== 1'b1 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL t3_hold: writes=%0d cnt=%0d m3=%h err=%b done=%b required 4 4 d 1 0", b_writes, b_count, b_mem[3], b_error, b_done);
        end
    endtask

    task automatic test_full_image();
        sel = 1'b1;
        clear_models();
        pulse_start(1'b1);
        checks++;
        if (b_error !== 1'b0) begin
            errors++;
            $display("FAIL t4_err_clear: err=%b required 0", b_error);
        end
        push(32'h1, 1'b0, 0);
        push(32'h2, 1'b0, 0);
        push(32'h3, 1'b0, 0);
        push(32'h0, 1'b1, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (b_done !== 1'b1 || b_cpu_hold !== 1'b0 || b_error !== 1'b0 || b_writes != 4 || b_count !== 3'd4
            || b_checksum !== 32'h6 || b_mem[0] !== 32'h1 || b_mem[3] !== 32'h0) begin
            errors++;
            $display("FAIL t4_halt_last: done=%b hold=%b err=%b writes=%0d cnt=%0d sum=%h m0=%h m3=%h required 1 0 0 4 4 6 1 0",
                     b_done, b_cpu_hold, b_error, b_writes, b_count, b_checksum, b_mem[0], b_mem[3]);
        end
        clear_models();
        pulse_start(1'b1);
        push(32'h1, 1'b0, 0);
        push(32'h2, 1'b0, 0);
        push(32'h3, 1'b0, 0);
        push(32'h13, 1'b1, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (b_error !== 1'b1 || b_done !== 1'b0 || b_cpu_hold !== 1'b1 || b_writes != 4 || b_mem[3] !== 32'h13 || b_mem[0] !== 32'h1) begin
            errors++;
            $display("FAIL t4_no_halt: err=%b done=%b hold=%b writes=%0d m3=%h m0=%h required 1 0 1 4 13 1",
                     b_error, b_done, b_cpu_hold, b_writes, b_mem[3], b_mem[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        sel = 1'b0;
        clear_models();
        pulse_start(1'b0);
        push(32'h100, 1'b0, 0);
        push(32'h200, 1'b0, 0);
        reset = 1'b0;
        #1;
        checks++;
        if ({a_in_ready, a_we, a_addr, a_wdata, a_cpu_hold, a_done, a_error, a_count, a_checksum}
            !== {1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0, 9'h0, 32'h0}) begin
            errors++;
            $display("FAIL t5_async: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b cnt=%0d sum=%h required 0 0 0 0 1 0 0 0 0",
                     a_in_ready, a_we, a_addr, a_wdata, a_cpu_hold, a_done, a_error, a_count, a_checksum);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (a_writes != 1 || a_mem[0] !== 32'h100 || a_mem[1] !== 32'hDEADBEEF || a_in_ready !== 1'b0 || a_cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL t5_after: writes=%0d m0=%h m1=%h rdy=%b hold=%b required 1 100 deadbeef 0 1",
                     a_writes, a_mem[0], a_mem[1], a_in_ready, a_cpu_hold);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_reload_from_run();
        test_overflow();
        test_full_image();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
